// File: rtl/regfile_wr_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Provides bus widths, reset/write-enable polarities, the zero word and
// the writeback request record carried through the port B buffer.
package regfile_wr_arb_pkg;

  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegBus     = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [RegBus-1:0]     ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] ZeroAddr = '0;

  // Port B buffer geometry; occupancy counts 0..FifoDepth.
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned OccBus    = 2;

  // Round-robin pointer encoding: which side was granted most recently.
  localparam logic RrALast = 1'b0;
  localparam logic RrBLast = 1'b1;

  typedef struct packed {
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer for long-latency writeback requests.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous reset (RstEnable polarity), empties the buffer
//   push       - enqueue push_data (ignored when full)
//   push_data  - request to enqueue
//   pop        - dequeue head (ignored when empty)
//   head       - oldest entry, valid when occupancy != 0
//   occupancy  - number of stored entries, 0..2
module wb_fifo2
  import regfile_wr_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_req_t           push_data,
  input  logic              pop,
  output wb_req_t           head,
  output logic [OccBus-1:0] occupancy
);

  localparam logic [OccBus-1:0] OccFull = OccBus'(FifoDepth);
  localparam logic [OccBus-1:0] OccOne  = OccBus'(1);
  localparam logic [OccBus-1:0] OccZero = '0;
  localparam wb_req_t           ReqZero = '{addr: ZeroAddr, data: ZeroWord};

  wb_req_t           r_slot0;  // head
  wb_req_t           r_slot1;
  logic [OccBus-1:0] r_count;

  logic w_push;
  logic w_pop;

  // A full buffer never accepts, even when it is popped in the same cycle.
  assign w_push = push && (r_count != OccFull);
  assign w_pop  = pop && (r_count != OccZero);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_count <= OccZero;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + OccOne;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - OccOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_slot0 <= ReqZero;
      r_slot1 <= ReqZero;
    end else begin
      // New entry lands at the head when the buffer is (or becomes) empty.
      if (w_push && ((r_count == OccZero) || (w_pop && (r_count == OccOne)))) begin
        r_slot0 <= push_data;
      end else if (w_pop) begin
        r_slot0 <= r_slot1;
      end
      if (w_push && !w_pop && (r_count == OccOne)) begin
        r_slot1 <= push_data;
      end
    end
  end

  assign head      = r_slot0;
  assign occupancy = r_count;

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter. Merges the pipeline writeback (port A)
// with buffered long-latency returns (port B) onto one registered write
// port, granting at most one request per cycle with round-robin fairness.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   a_valid/a_addr/a_data       - port A request; a_ready = accepted this cycle
//   b_valid/b_addr/b_data       - port B request; b_ready = buffered this cycle
//   we/waddr/wdata              - registered register-file write port
//   b_pending                   - port B buffer occupancy
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [RegAddrBus-1:0] a_addr,
  input  logic [RegBus-1:0]     a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [RegAddrBus-1:0] b_addr,
  input  logic [RegBus-1:0]     b_data,
  output logic                  b_ready,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata,
  output logic [OccBus-1:0]     b_pending
);

  logic              w_in_rst;
  logic              w_b_push;
  logic              w_head_valid;
  logic              w_grant_a;
  logic              w_grant_b;
  logic [OccBus-1:0] w_occ;
  wb_req_t           w_head;
  wb_req_t           w_b_req;
  wb_req_t           w_sel;

  logic r_rr_last;

  assign w_in_rst     = (rst == RstEnable);
  assign w_b_req      = '{addr: b_addr, data: b_data};
  assign w_head_valid = (w_occ != '0);

  assign b_ready  = !w_in_rst && (w_occ < OccBus'(FifoDepth));
  assign w_b_push = b_valid && b_ready;

  wb_fifo2 u_wb_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .push      (w_b_push),
    .push_data (w_b_req),
    .pop       (w_grant_b),
    .head      (w_head),
    .occupancy (w_occ)
  );

  // A wins a contest only if the buffer head was granted most recently.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!w_in_rst) begin
      if (a_valid && (!w_head_valid || (r_rr_last == RrBLast))) begin
        w_grant_a = 1'b1;
      end else if (w_head_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = w_head;
    if (w_grant_a) begin
      w_sel = '{addr: a_addr, data: a_data};
    end
  end

  assign a_ready   = w_grant_a;
  assign b_pending = w_occ;

  always_ff @(posedge clk) begin
    if (w_in_rst) begin
      r_rr_last <= RrBLast;
    end else if (w_grant_a) begin
      r_rr_last <= RrALast;
    end else if (w_grant_b) begin
      r_rr_last <= RrBLast;
    end
  end

  // Writes to r0 are consumed but never enabled.
  always_ff @(posedge clk) begin
    if (w_in_rst) begin
      we    <= ~WriteEnable;
      waddr <= ZeroAddr;
      wdata <= ZeroWord;
    end else if (w_grant_a || w_grant_b) begin
      we    <= (w_sel.addr != ZeroAddr) ? WriteEnable : ~WriteEnable;
      waddr <= w_sel.addr;
      wdata <= w_sel.data;
    end else begin
      we <= ~WriteEnable;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb. Inputs change 1 time unit after the
// rising edge; combinational outputs are checked shortly after, registered
// outputs right after the following edge.
module tb_regfile_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  b_pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .b_pending (b_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] ad, input logic [31:0] d);
    a_valid = v;
    a_addr  = ad;
    a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] ad, input logic [31:0] d);
    b_valid = v;
    b_addr  = ad;
    b_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  // Checks the registered write port after an edge.
  task automatic chk_wr(input string tag, input logic [4:0] ad, input logic [31:0] d);
    chk({tag, "_we"}, we, 1'b1);
    chk({tag, "_waddr"}, waddr, ad);
    chk({tag, "_wdata"}, wdata, d);
  endtask

  initial begin
    // Reset state, with requests asserted to confirm nothing is accepted.
    rst = 1'b1;
    drive_a(1'b1, 5'd4, 32'h4444_4444);
    drive_b(1'b1, 5'd6, 32'h6666_6666);
    tick();
    tick();
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_pending", b_pending, 2'd0);
    do_reset();

    // Port A alone: accepted same cycle, written next cycle, then held.
    drive_a(1'b1, 5'd3, 32'h1234_5678);
    #1;
    chk("aonly_ready", a_ready, 1'b1);
    tick();
    chk_wr("aonly", 5'd3, 32'h1234_5678);
    drive_a(1'b0, 5'd0, 32'h0);
    tick();
    chk("aonly_idle_we", we, 1'b0);
    chk("aonly_hold_waddr", waddr, 5'd3);
    chk("aonly_hold_wdata", wdata, 32'h1234_5678);

    // Contest after reset: A wins first, buffered r5 follows.
    do_reset();
    drive_b(1'b1, 5'd5, 32'hAAAA_0000);
    tick();
    drive_b(1'b0, 5'd0, 32'h0);
    drive_a(1'b1, 5'd7, 32'hBBBB_0000);
    #1;
    chk("cont_pend1", b_pending, 2'd1);
    chk("cont_a_ready1", a_ready, 1'b1);
    tick();
    chk_wr("cont_first", 5'd7, 32'hBBBB_0000);
    #1;
    chk("cont_a_ready2", a_ready, 1'b0);
    tick();
    drive_a(1'b0, 5'd0, 32'h0);
    chk_wr("cont_second", 5'd5, 32'hAAAA_0000);
    chk("cont_pend0", b_pending, 2'd0);

    // Back-pressure: A held busy while B streams; buffer fills, writes alternate.
    do_reset();
    drive_a(1'b1, 5'd8, 32'hA000_0000);
    drive_b(1'b1, 5'd16, 32'hB000_0000);
    #1;
    chk("bp_c0_a_ready", a_ready, 1'b1);
    chk("bp_c0_b_ready", b_ready, 1'b1);
    tick();
    chk_wr("bp_w0", 5'd8, 32'hA000_0000);
    drive_a(1'b1, 5'd9, 32'hA111_1111);
    drive_b(1'b1, 5'd17, 32'hB111_1111);
    #1;
    chk("bp_c1_a_ready", a_ready, 1'b0);
    chk("bp_c1_pend", b_pending, 2'd1);
    tick();
    chk_wr("bp_w1", 5'd16, 32'hB000_0000);
    drive_b(1'b1, 5'd18, 32'hB222_2222);
    #1;
    chk("bp_c2_a_ready", a_ready, 1'b1);
    tick();
    chk_wr("bp_w2", 5'd9, 32'hA111_1111);
    drive_a(1'b1, 5'd10, 32'hA222_2222);
    drive_b(1'b1, 5'd19, 32'hB333_3333);
    #1;
    chk("bp_c3_pend", b_pending, 2'd2);
    chk("bp_c3_b_ready", b_ready, 1'b0);
    chk("bp_c3_a_ready", a_ready, 1'b0);
    tick();
    chk_wr("bp_w3", 5'd17, 32'hB111_1111);
    #1;
    chk("bp_c4_a_ready", a_ready, 1'b1);
    chk("bp_c4_b_ready", b_ready, 1'b1);
    tick();
    chk_wr("bp_w4", 5'd10, 32'hA222_2222);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    #1;
    chk("bp_c5_pend", b_pending, 2'd2);
    tick();
    chk_wr("bp_w5", 5'd18, 32'hB222_2222);
    tick();
    chk_wr("bp_w6", 5'd19, 32'hB333_3333);
    tick();
    chk("bp_drain_we", we, 1'b0);
    chk("bp_drain_pend", b_pending, 2'd0);

    // Zero address: consumed, no write enable.
    drive_a(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("zero_a_ready", a_ready, 1'b1);
    tick();
    drive_a(1'b0, 5'd0, 32'h0);
    chk("zero_we", we, 1'b0);

    // Reset while two entries are buffered: they are dropped.
    do_reset();
    drive_a(1'b1, 5'd11, 32'hC000_0000);
    drive_b(1'b1, 5'd20, 32'hD000_0000);
    tick();
    drive_a(1'b1, 5'd12, 32'hC111_1111);
    drive_b(1'b1, 5'd21, 32'hD111_1111);
    tick();
    drive_b(1'b1, 5'd22, 32'hD222_2222);
    tick();
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    chk("mid_pend2", b_pending, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pend", b_pending, 2'd0);
    chk("mid_rst_we", we, 1'b0);
    tick();
    chk("mid_after1_we", we, 1'b0);
    tick();
    chk("mid_after2_we", we, 1'b0);
    chk("mid_after2_waddr", waddr, 5'd0);

    // Port B ordering with A idle: r1 then r2, two cycles after each push.
    drive_b(1'b1, 5'd1, 32'hD1D1_D1D1);
    tick();
    chk("ord_n1_we", we, 1'b0);
    drive_b(1'b1, 5'd2, 32'hD2D2_D2D2);
    tick();
    drive_b(1'b0, 5'd0, 32'h0);
    chk_wr("ord_w1", 5'd1, 32'hD1D1_D1D1);
    tick();
    chk_wr("ord_w2", 5'd2, 32'hD2D2_D2D2);
    tick();
    chk("ord_end_we", we, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
